// File: rtl/pdu_pkg.sv
// Shared definitions for the PDU display path: data width, arbiter state
// encoding and the rotate-priority pick used to choose the next display owner.
package pdu_pkg;

   localparam int DISP_W = 32;
   localparam int MAXREQ = 8;

   typedef enum logic {
      DA_IDLE  = 1'b0,
      DA_GRANT = 1'b1
   } daState_e;

   // Scans req starting one past ptr and wrapping over nreq entries; the
   // first set bit wins. With excl set, the entry at ptr itself is skipped
   // so the current owner can never re-win its own rotation slot.
   // Returns {found, idx}.
   function automatic logic [3:0] rr_pick(input logic [MAXREQ-1:0] req,
                                          input logic [2:0]        ptr,
                                          input logic              excl,
                                          input int                nreq);
      logic       found;
      logic [2:0] idx;
      int         k;
      found = 1'b0;
      idx   = 3'd0;
      for (int i = 1; i <= MAXREQ; i++) begin
         k = (int'(ptr) + i) % nreq;
         if ((i <= nreq) && !found && req[k] && !(excl && (k == int'(ptr)))) begin
            found = 1'b1;
            idx   = 3'(k);
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Pure combinational round-robin picker: widens the request vector to the
// package's maximum width and applies the shared rotate-priority scan.
module rr_picker
   import pdu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            excl,
   output logic            found,
   output logic [IDW-1:0]  idx
);

   logic [MAXREQ-1:0] reqPad;
   logic [2:0]        ptrPad;
   logic [3:0]        pick;

   // Pad inputs to the fixed width the shared function expects, then split
   // the packed {found, idx} result back into the two outputs.
   always_comb begin
      reqPad             = '0;
      reqPad[NREQ-1:0]   = req;
      ptrPad             = '0;
      ptrPad[IDW-1:0]    = ptr;
      pick               = rr_pick(reqPad, ptrPad, excl, NREQ);
      found              = pick[3];
      idx                = IDW'(pick[2:0]);
   end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Seven-segment display arbiter: hands the 32-bit display word to one of
// NREQ requesters at a time, keeps each owner for at least HOLD_CYC cycles
// and rotates round-robin among pending requesters.
module seg_disp_arbiter
   import pdu_pkg::*;
#(
   parameter  int NREQ     = 4,
   parameter  int HOLD_CYC = 50_000_000,
   localparam int IDW      = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NREQ-1:0]        req,
   input  logic [DISP_W*NREQ-1:0] data,
   input  logic                   lock,
   output logic [NREQ-1:0]        gnt,
   output logic [IDW-1:0]         owner_id,
   output logic [DISP_W-1:0]      disp_data,
   output logic                   disp_valid,
   output logic                   switch_pls
);

   localparam int DW = $clog2(HOLD_CYC);

   daState_e          state,     stateNxt;
   logic [NREQ-1:0]   gntNxt;
   logic [IDW-1:0]    rrPtr,     rrPtrNxt;
   logic [DISP_W-1:0] dispData,  dispNxt;
   logic              switchPls, plsNxt;
   logic [DW-1:0]     dwell,     dwellNxt;

   logic [DISP_W-1:0] words [NREQ];
   logic              pickFound;
   logic [IDW-1:0]    pickIdx;
   logic              ownerReq;
   logic              dwellDone;
   logic              doSwitch;

   for (genvar i = 0; i < NREQ; i++) begin : g_words
      assign words[i] = data[DISP_W*i +: DISP_W];
   end

   rr_picker #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_picker (
      .req   (req),
      .ptr   (rrPtr),
      .excl  (state == DA_GRANT),
      .found (pickFound),
      .idx   (pickIdx)
   );

   assign ownerReq  = req[rrPtr];
   assign dwellDone = (dwell == DW'(HOLD_CYC - 1));

   // Next-state logic. rrPtr is both the rotation pointer and the reported
   // owner, since the last owner is by definition where the scan resumes.
   // A dropped owner request always wins over lock and over dwell expiry.
   always_comb begin
      stateNxt = state;
      gntNxt   = gnt;
      rrPtrNxt = rrPtr;
      dispNxt  = dispData;
      plsNxt   = 1'b0;
      dwellNxt = dwell;
      doSwitch = 1'b0;
      case (state)
         DA_IDLE: begin
            doSwitch = pickFound;
         end
         DA_GRANT: begin
            if (!ownerReq) begin
               if (pickFound) begin
                  doSwitch = 1'b1;
               end else begin
                  stateNxt = DA_IDLE;
                  gntNxt   = '0;
                  plsNxt   = 1'b1;
                  dwellNxt = '0;
               end
            end else if (dwellDone && !lock && pickFound) begin
               doSwitch = 1'b1;
            end else begin
               dispNxt = words[rrPtr];
               if (!dwellDone) dwellNxt = dwell + DW'(1);
            end
         end
      endcase
      if (doSwitch) begin
         stateNxt = DA_GRANT;
         gntNxt   = NREQ'(1) << pickIdx;
         rrPtrNxt = pickIdx;
         dispNxt  = words[pickIdx];
         dwellNxt = '0;
         plsNxt   = 1'b1;
      end
   end

   // State and output registers; reset drops any grant immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= DA_IDLE;
         gnt       <= '0;
         rrPtr     <= '0;
         dispData  <= '0;
         switchPls <= 1'b0;
         dwell     <= '0;
      end else begin
         state     <= stateNxt;
         gnt       <= gntNxt;
         rrPtr     <= rrPtrNxt;
         dispData  <= dispNxt;
         switchPls <= plsNxt;
         dwell     <= dwellNxt;
      end
   end

   assign owner_id   = rrPtr;
   assign disp_data  = dispData;
   assign disp_valid = |gnt;
   assign switch_pls = switchPls;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed testbench for seg_disp_arbiter with NREQ=4, HOLD_CYC=8.
module tb_seg_disp_arbiter;

   localparam int NREQ     = 4;
   localparam int HOLD_CYC = 8;

   logic         clk;
   logic         rstn;
   logic [3:0]   req;
   logic         lock;
   logic [31:0]  words [4];
   logic [127:0] data;
   logic [3:0]   gnt;
   logic [1:0]   owner_id;
   logic [31:0]  disp_data;
   logic         disp_valid;
   logic         switch_pls;

   int vectors;
   int miscompares;

   assign data = {words[3], words[2], words[1], words[0]};

   seg_disp_arbiter #(
      .NREQ     (NREQ),
      .HOLD_CYC (HOLD_CYC)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req        (req),
      .data       (data),
      .lock       (lock),
      .gnt        (gnt),
      .owner_id   (owner_id),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .switch_pls (switch_pls)
   );

   // Free-running 100 MHz-style clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic setDefaultWords();
      words[0] = 32'hC0DE_0000;
      words[1] = 32'hC0DE_1111;
      words[2] = 32'hC0DE_2222;
      words[3] = 32'hC0DE_3333;
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic l);
      req  = r;
      lock = l;
   endtask

   // One clock, then the always-true invariants checked on the settled outputs.
   task automatic stepClock();
      @(posedge clk);
      #1;
      vectors++;
      if (!$onehot0(gnt)) begin
         miscompares++;
         $display("[TB] FAIL inv_onehot0: got %b expected one-hot or zero", gnt);
      end
      vectors++;
      if (disp_valid !== (|gnt)) begin
         miscompares++;
         $display("[TB] FAIL inv_valid: got %b expected %b", disp_valid, |gnt);
      end
      if (disp_valid === 1'b1) begin
         vectors++;
         if (gnt !== (4'b0001 << owner_id)) begin
            miscompares++;
            $display("[TB] FAIL inv_owner: got gnt %b owner %0d", gnt, owner_id);
         end
      end
   endtask

   task automatic doReset(input logic [3:0] r, input logic l);
      rstn = 1'b0;
      applyStimulus(r, l);
      setDefaultWords();
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      applyStimulus(4'hF, 1'b0);
      setDefaultWords();
      @(posedge clk);
      #3;
      vectors++;
      if (gnt !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
      end
      vectors++;
      if (disp_data !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: got %h expected %h", disp_data, 32'h0);
      end
      vectors++;
      if (disp_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_valid: got %b expected 0", disp_valid);
      end
      vectors++;
      if (owner_id !== 2'd0 || switch_pls !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_owner_pls: got %0d/%b expected 0/0", owner_id, switch_pls);
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      stepClock();
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL first_gnt: got %b expected %b", gnt, 4'b0010);
      end
      vectors++;
      if (disp_data !== 32'hC0DE_1111) begin
         miscompares++;
         $display("[TB] FAIL first_data: got %h expected %h", disp_data, 32'hC0DE_1111);
      end
      vectors++;
      if (switch_pls !== 1'b1 || owner_id !== 2'd1) begin
         miscompares++;
         $display("[TB] FAIL first_pls_owner: got %b/%0d expected 1/1", switch_pls, owner_id);
      end
      stepClock();
      vectors++;
      if (switch_pls !== 1'b0 || gnt !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL first_pls_width: got %b/%b expected 0/0010", switch_pls, gnt);
      end
   endtask

   task automatic test_dwell();
      logic [3:0] expG;
      logic       expP;
      doReset(4'b0011, 1'b0);
      stepClock();
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL dwell_start: got %b expected %b", gnt, 4'b0010);
      end
      for (int c = 1; c <= 16; c++) begin
         stepClock();
         expG = (((c / 8) % 2) == 0) ? 4'b0010 : 4'b0001;
         expP = ((c % 8) == 0);
         vectors++;
         if (gnt !== expG || switch_pls !== expP) begin
            miscompares++;
            $display("[TB] FAIL dwell_cyc%0d: got %b/%b expected %b/%b", c, gnt, switch_pls, expG, expP);
         end
         if (c == 8) begin
            vectors++;
            if (disp_data !== 32'hC0DE_0000) begin
               miscompares++;
               $display("[TB] FAIL dwell_newdata: got %h expected %h", disp_data, 32'hC0DE_0000);
            end
         end
      end
      words[1] = 32'hBEEF_0001;
      vectors++;
      if (disp_data !== 32'hC0DE_1111) begin
         miscompares++;
         $display("[TB] FAIL live_before: got %h expected %h", disp_data, 32'hC0DE_1111);
      end
      stepClock();
      vectors++;
      if (disp_data !== 32'hBEEF_0001) begin
         miscompares++;
         $display("[TB] FAIL live_after: got %h expected %h", disp_data, 32'hBEEF_0001);
      end
   endtask

   task automatic test_release();
      doReset(4'b0100, 1'b0);
      stepClock();
      vectors++;
      if (gnt !== 4'b0100) begin
         miscompares++;
         $display("[TB] FAIL rel_start: got %b expected %b", gnt, 4'b0100);
      end
      stepClock();
      stepClock();
      applyStimulus(4'b1000, 1'b0);
      stepClock();
      vectors++;
      if (gnt !== 4'b1000 || switch_pls !== 1'b1 || owner_id !== 2'd3) begin
         miscompares++;
         $display("[TB] FAIL rel_switch: got %b/%b/%0d expected 1000/1/3", gnt, switch_pls, owner_id);
      end
      stepClock();
      vectors++;
      if (switch_pls !== 1'b0 || disp_data !== 32'hC0DE_3333) begin
         miscompares++;
         $display("[TB] FAIL rel_track: got %b/%h expected 0/%h", switch_pls, disp_data, 32'hC0DE_3333);
      end
      applyStimulus(4'b0000, 1'b0);
      words[3] = 32'hDEAD_0003;
      stepClock();
      vectors++;
      if (gnt !== 4'b0000 || disp_valid !== 1'b0 || switch_pls !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rel_idle: got %b/%b/%b expected 0000/0/1", gnt, disp_valid, switch_pls);
      end
      vectors++;
      if (disp_data !== 32'hC0DE_3333) begin
         miscompares++;
         $display("[TB] FAIL rel_idle_hold: got %h expected %h", disp_data, 32'hC0DE_3333);
      end
      stepClock();
      vectors++;
      if (switch_pls !== 1'b0 || disp_data !== 32'hC0DE_3333 || owner_id !== 2'd3) begin
         miscompares++;
         $display("[TB] FAIL rel_idle_stay: got %b/%h/%0d expected 0/%h/3", switch_pls, disp_data, owner_id, 32'hC0DE_3333);
      end
   endtask

   task automatic test_lock();
      int bad;
      doReset(4'hF, 1'b1);
      stepClock();
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL lock_start: got %b expected %b", gnt, 4'b0010);
      end
      bad = 0;
      for (int c = 1; c <= 40; c++) begin
         stepClock();
         vectors++;
         if (gnt !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL lock_hold_cyc%0d: got %b expected %b", c, gnt, 4'b0010);
         end
      end
      applyStimulus(4'hF, 1'b0);
      stepClock();
      vectors++;
      if (gnt !== 4'b0100 || switch_pls !== 1'b1 || owner_id !== 2'd2) begin
         miscompares++;
         $display("[TB] FAIL lock_release: got %b/%b/%0d expected 0100/1/2", gnt, switch_pls, owner_id);
      end
   endtask

   task automatic test_wrap();
      doReset(4'b1000, 1'b0);
      stepClock();
      vectors++;
      if (gnt !== 4'b1000) begin
         miscompares++;
         $display("[TB] FAIL wrap_start: got %b expected %b", gnt, 4'b1000);
      end
      applyStimulus(4'b1001, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         stepClock();
         vectors++;
         if (gnt !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL wrap_hold_cyc%0d: got %b expected %b", c, gnt, 4'b1000);
         end
      end
      stepClock();
      vectors++;
      if (gnt !== 4'b0001 || owner_id !== 2'd0 || switch_pls !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wrap_switch: got %b/%0d/%b expected 0001/0/1", gnt, owner_id, switch_pls);
      end
      applyStimulus(4'b1110, 1'b0);
      stepClock();
      vectors++;
      if (gnt !== 4'b0010 || owner_id !== 2'd1) begin
         miscompares++;
         $display("[TB] FAIL wrap_next: got %b/%0d expected 0010/1", gnt, owner_id);
      end
   endtask

   task automatic test_single();
      doReset(4'b0001, 1'b0);
      stepClock();
      vectors++;
      if (gnt !== 4'b0001 || switch_pls !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL single_start: got %b/%b expected 0001/1", gnt, switch_pls);
      end
      for (int c = 1; c <= 20; c++) begin
         stepClock();
         vectors++;
         if (gnt !== 4'b0001 || switch_pls !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_cyc%0d: got %b/%b expected 0001/0", c, gnt, switch_pls);
         end
      end
   endtask

   task automatic test_async_reset();
      doReset(4'b0011, 1'b0);
      stepClock();
      for (int c = 1; c <= 5; c++) stepClock();
      vectors++;
      if (gnt !== 4'b0010 || disp_data !== 32'hC0DE_1111) begin
         miscompares++;
         $display("[TB] FAIL areset_pre: got %b/%h expected 0010/%h", gnt, disp_data, 32'hC0DE_1111);
      end
      #2;
      rstn = 1'b0;
      #1;
      vectors++;
      if (gnt !== 4'b0000 || disp_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL areset_gnt: got %b/%b expected 0000/0", gnt, disp_valid);
      end
      vectors++;
      if (disp_data !== 32'h0 || owner_id !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL areset_data: got %h/%0d expected 0/0", disp_data, owner_id);
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Main sequence: each scenario in turn, then the summary.
   initial begin
      vectors     = 0;
      miscompares = 0;
      rstn        = 1'b0;
      req         = 4'h0;
      lock        = 1'b0;
      setDefaultWords();
      $display("[TB] starting seg_disp_arbiter bench");
      test_reset();
      test_dwell();
      test_release();
      test_lock();
      test_wrap();
      test_single();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
